// File: rtl/moving_average_filter.sv
// N-tap moving-average (boxcar) filter with a circular sample buffer and a
// running-sum accumulator. Window length N = 2**LOG2_LEN, samples unsigned or
// two's complement (SIGNED), one-cycle latency, no backpressure.
// Optional feature: define MOVING_AVERAGE_ROUND_EN to round half toward
// +infinity (with saturation) instead of truncating toward -infinity.
module moving_average_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int LOG2_LEN   = 3,
  parameter int SIGNED     = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ce,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ce,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_primed
);

  localparam int N      = 1 << LOG2_LEN;
  localparam int ACC_W  = DATA_WIDTH + LOG2_LEN;
  localparam int PTR_W  = (LOG2_LEN > 0) ? LOG2_LEN : 1;
  localparam int CNT_W  = LOG2_LEN + 1;

  logic [DATA_WIDTH-1:0] sample_buf [N];
  logic [ACC_W-1:0]      acc_p0;
  logic [ACC_W-1:0]      acc_next;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      wr_ptr_next;
  logic [CNT_W-1:0]      fill_cnt;
  logic [CNT_W-1:0]      fill_next;
  logic [DATA_WIDTH-1:0] old_sample;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  vld_p1;
  logic                  primed_p1;

  // Widen a sample to accumulator width: sign-extend in signed mode.
  function automatic logic [ACC_W-1:0] ext(input logic [DATA_WIDTH-1:0] x);
    logic signed [DATA_WIDTH-1:0] sx;
    sx = x;
    if (SIGNED != 0) return ACC_W'(sx);
    else             return ACC_W'(x);
  endfunction

`ifdef MOVING_AVERAGE_ROUND_EN
  localparam int ACC_W1  = ACC_W + 1;
  localparam int ROUND_K = (1 << LOG2_LEN) >> 1;  // zero when N == 1

  // Round half toward +inf, then saturate to the sample range. The adder is
  // one bit wider than the accumulator so the rounding constant cannot wrap.
  function automatic logic [DATA_WIDTH-1:0] avg_out(input logic [ACC_W-1:0] a);
    logic signed [ACC_W-1:0]  sa;
    logic        [ACC_W1-1:0] w;
    logic signed [ACC_W1-1:0] sw;
    logic        [ACC_W1-1:0] q;
    sa = a;
    if (SIGNED != 0) w = ACC_W1'(sa);
    else             w = ACC_W1'(a);
    w  = w + ACC_W1'(ROUND_K);
    sw = w;
    if (SIGNED != 0) begin
      q = sw >>> LOG2_LEN;
      if (!q[DATA_WIDTH] && q[DATA_WIDTH-1])
        return {1'b0, {(DATA_WIDTH-1){1'b1}}};
      return q[DATA_WIDTH-1:0];
    end else begin
      q = w >> LOG2_LEN;
      if (q[DATA_WIDTH])
        return {DATA_WIDTH{1'b1}};
      return q[DATA_WIDTH-1:0];
    end
  endfunction
`else
  // Divide by N with truncation toward -inf; the quotient always fits.
  function automatic logic [DATA_WIDTH-1:0] avg_out(input logic [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sa;
    logic        [ACC_W-1:0] q;
    sa = a;
    if (SIGNED != 0) q = sa >>> LOG2_LEN;
    else             q = a >> LOG2_LEN;
    return q[DATA_WIDTH-1:0];
  endfunction
`endif

  // Next-state: read the oldest sample, update running sum, advance pointer/fill.
  always_comb begin
    old_sample  = sample_buf[wr_ptr];
    acc_next    = acc_p0 + ext(i_data) - ext(old_sample);
    wr_ptr_next = (LOG2_LEN == 0) ? '0 : wr_ptr + PTR_W'(1);
    fill_next   = (fill_cnt == CNT_W'(N)) ? fill_cnt : fill_cnt + CNT_W'(1);
  end

  // Stage p0 -> p1: commit the sample and register the averaged output.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < N; i++) sample_buf[i] <= '0;
      acc_p0    <= '0;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      data_p1   <= '0;
      vld_p1    <= 1'b0;
      primed_p1 <= 1'b0;
    end else if (i_ce) begin
      sample_buf[wr_ptr] <= i_data;
      acc_p0    <= acc_next;
      wr_ptr    <= wr_ptr_next;
      fill_cnt  <= fill_next;
      data_p1   <= avg_out(acc_next);
      vld_p1    <= 1'b1;
      primed_p1 <= primed_p1 | (fill_next == CNT_W'(N));
    end else begin
      vld_p1    <= 1'b0;
    end
  end

  assign o_ce     = vld_p1;
  assign o_data   = data_p1;
  assign o_primed = primed_p1;

endmodule

// File: tb/tb_moving_average_filter.sv
// Bench for moving_average_filter: an unsigned and a signed instance share the
// same stimulus; a window model feeds per-instance expected-value queues.
module tb_moving_average_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce  = 1'b0;
  logic [7:0] din = 8'h00;

  logic       o_ce_u, o_primed_u, o_ce_s, o_primed_s;
  logic [7:0] o_data_u, o_data_s;

  int n_checks = 0;
  int n_errors = 0;

  int         win_u [8];
  int         win_s [8];
  int         wp   = 0;
  int         fill = 0;
  logic [7:0] exp_q_u [$];
  logic [7:0] exp_q_s [$];
  logic [7:0] last_u = 8'h00;
  logic [7:0] last_s = 8'h00;
  logic [7:0] exp_u, exp_s;

  moving_average_filter #(.DATA_WIDTH(8), .LOG2_LEN(3), .SIGNED(0)) dut_u (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_data(din),
    .o_ce(o_ce_u), .o_data(o_data_u), .o_primed(o_primed_u)
  );

  moving_average_filter #(.DATA_WIDTH(8), .LOG2_LEN(3), .SIGNED(1)) dut_s (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_data(din),
    .o_ce(o_ce_s), .o_data(o_data_s), .o_primed(o_primed_s)
  );

  always #5 clk = ~clk;

  function automatic int fdiv8(input int s);
    int q;
    q = s / 8;
    if (s < 0 && (s % 8) != 0) q = q - 1;
    return q;
  endfunction

  // Average of the full 8-entry window (empty slots hold zero).
  function automatic logic [7:0] model_avg(input int w[8], input bit sgn);
    int s, q;
    s = 0;
    for (int i = 0; i < 8; i++) s += w[i];
`ifdef MOVING_AVERAGE_ROUND_EN
    q = fdiv8(s + 4);
    if (!sgn && q > 255) q = 255;
    if (sgn && q > 127) q = 127;
`else
    q = fdiv8(s);
`endif
    return 8'(q);
  endfunction

  // Drive one cycle of stimulus, update the model, sample #1 after the edge.
  task automatic drive(input logic r, input logic c, input logic [7:0] d);
    @(negedge clk);
    rst = r; ce = c; din = d;
    if (r) begin
      for (int i = 0; i < 8; i++) begin win_u[i] = 0; win_s[i] = 0; end
      wp = 0; fill = 0; last_u = 8'h00; last_s = 8'h00;
      exp_q_u.delete(); exp_q_s.delete();
    end else if (c) begin
      win_u[wp] = int'(d);
      win_s[wp] = int'($signed(d));
      wp = (wp + 1) % 8;
      if (fill < 8) fill++;
      exp_q_u.push_back(model_avg(win_u, 1'b0));
      exp_q_s.push_back(model_avg(win_s, 1'b1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 8'hFF);
      n_checks++;
      if ({o_ce_u, o_data_u, o_primed_u} !== 10'b0) begin
        n_errors++;
        $display("FAIL reset_u[%0d]: got ce=%b data=%h primed=%b, want 0/00/0", i, o_ce_u, o_data_u, o_primed_u);
      end
      n_checks++;
      if ({o_ce_s, o_data_s, o_primed_s} !== 10'b0) begin
        n_errors++;
        $display("FAIL reset_s[%0d]: got ce=%b data=%h primed=%b, want 0/00/0", i, o_ce_s, o_data_s, o_primed_s);
      end
    end
  endtask

  task automatic test_step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 8'h80);
      exp_u = exp_q_u.pop_front();
      exp_s = exp_q_s.pop_front();
      n_checks++;
      if (o_ce_u !== 1'b1 || o_data_u !== exp_u || o_primed_u !== (i >= 7)) begin
        n_errors++;
        $display("FAIL step_u[%0d]: got ce=%b data=%h primed=%b, want 1/%h/%b", i, o_ce_u, o_data_u, o_primed_u, exp_u, i >= 7);
      end
      n_checks++;
      if (o_ce_s !== 1'b1 || o_data_s !== exp_s || o_primed_s !== (i >= 7)) begin
        n_errors++;
        $display("FAIL step_s[%0d]: got ce=%b data=%h primed=%b, want 1/%h/%b", i, o_ce_s, o_data_s, o_primed_s, exp_s, i >= 7);
      end
      last_u = exp_u; last_s = exp_s;
    end
  endtask

  task automatic test_gapped();
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, (i % 2) == 0, 8'h08);
      if ((i % 2) == 0) begin
        exp_u = exp_q_u.pop_front();
        exp_s = exp_q_s.pop_front();
        n_checks++;
        if (o_ce_u !== 1'b1 || o_data_u !== exp_u || o_data_u !== 8'(i / 2 + 1)) begin
          n_errors++;
          $display("FAIL gapped_u[%0d]: got ce=%b data=%h, want 1/%h", i, o_ce_u, o_data_u, exp_u);
        end
        n_checks++;
        if (o_ce_s !== 1'b1 || o_data_s !== exp_s) begin
          n_errors++;
          $display("FAIL gapped_s[%0d]: got ce=%b data=%h, want 1/%h", i, o_ce_s, o_data_s, exp_s);
        end
        last_u = exp_u; last_s = exp_s;
      end else begin
        n_checks++;
        if (o_ce_u !== 1'b0 || o_data_u !== last_u || o_ce_s !== 1'b0 || o_data_s !== last_s) begin
          n_errors++;
          $display("FAIL gapped_hold[%0d]: got ce=%b/%b data=%h/%h, want 0/0 %h/%h", i, o_ce_u, o_ce_s, o_data_u, o_data_s, last_u, last_s);
        end
      end
    end
  endtask

  // Fill the window with sample a, then replace every entry with sample b.
  task automatic test_two_phase(input string name, input logic [7:0] a, input logic [7:0] b);
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, (i < 8) ? a : b);
      exp_u = exp_q_u.pop_front();
      exp_s = exp_q_s.pop_front();
      n_checks++;
      if (o_ce_u !== 1'b1 || o_data_u !== exp_u) begin
        n_errors++;
        $display("FAIL %s_u[%0d]: got ce=%b data=%h, want 1/%h", name, i, o_ce_u, o_data_u, exp_u);
      end
      n_checks++;
      if (o_ce_s !== 1'b1 || o_data_s !== exp_s) begin
        n_errors++;
        $display("FAIL %s_s[%0d]: got ce=%b data=%h, want 1/%h", name, i, o_ce_s, o_data_s, exp_s);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] want;
`ifdef MOVING_AVERAGE_ROUND_EN
    want = 8'h02;
`else
    want = 8'h01;
`endif
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'h40);
    exp_q_u.delete(); exp_q_s.delete();
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h0C);
    exp_u = exp_q_u.pop_front();
    exp_s = exp_q_s.pop_front();
    n_checks++;
    if (o_ce_u !== 1'b1 || o_data_u !== want || o_primed_u !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_u: got ce=%b data=%h primed=%b, want 1/%h/0", o_ce_u, o_data_u, o_primed_u, want);
    end
    n_checks++;
    if (o_ce_s !== 1'b1 || o_data_s !== exp_s || o_primed_s !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_s: got ce=%b data=%h primed=%b, want 1/%h/0", o_ce_s, o_data_s, o_primed_s, exp_s);
    end
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'hFF);
    n_checks++;
    if (o_data_u !== 8'hFF || o_primed_u !== 1'b1) begin
      n_errors++;
      $display("FAIL full_scale_u: got data=%h primed=%b, want FF/1", o_data_u, o_primed_u);
    end
    n_checks++;
    if (o_data_s !== 8'hFF) begin
      n_errors++;
      $display("FAIL full_scale_s: got data=%h, want FF", o_data_s);
    end
  endtask

  task automatic test_back_to_back();
    logic       c;
    logic [7:0] d;
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 60; i++) begin
      c = ($urandom_range(0, 3) != 0);
      d = 8'($urandom_range(0, 255));
      drive(1'b0, c, d);
      if (c) begin
        exp_u = exp_q_u.pop_front();
        exp_s = exp_q_s.pop_front();
        last_u = exp_u; last_s = exp_s;
      end
      n_checks++;
      if (o_ce_u !== c || o_data_u !== last_u || o_primed_u !== (fill == 8)) begin
        n_errors++;
        $display("FAIL b2b_u[%0d]: got ce=%b data=%h primed=%b, want %b/%h/%b", i, o_ce_u, o_data_u, o_primed_u, c, last_u, fill == 8);
      end
      n_checks++;
      if (o_ce_s !== c || o_data_s !== last_s || o_primed_s !== (fill == 8)) begin
        n_errors++;
        $display("FAIL b2b_s[%0d]: got ce=%b data=%h primed=%b, want %b/%h/%b", i, o_ce_s, o_data_s, o_primed_s, c, last_s, fill == 8);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin win_u[i] = 0; win_s[i] = 0; end
    test_reset();
    test_step();
    test_gapped();
    test_two_phase("wrap", 8'hFF, 8'h00);
    test_two_phase("signed", 8'hF8, 8'h08);
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
